kb_scan_decoder: RTL

//  Consumes the received-byte stream of the PS/2 keyboard controller (rx_done/dout), strips E0/F0 prefixes
//  and buffers {ext,brk,code} key events in a FIFO for the host. Also sequences the LED command
//  (ED, led byte) back through the controller's we_ps2/din/tx_done path, with ACK (FA) and resend (FE) handling.

---
 rtl/kb_scan_decoder_pkg.sv | 54 +++++
 rtl/kb_scan_decoder_fifo.sv | 64 ++++++
 rtl/kb_scan_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/kb_scan_decoder_pkg.sv
// Shared PS/2 keyboard definitions: protocol byte values, byte classes and the
// state encodings of the scan decoder's prefix and LED-command FSMs.
package kb_scan_decoder_pkg;

  localparam logic [7:0] KB_ACK     = 8'hFA;
  localparam logic [7:0] KB_RESEND  = 8'hFE;
  localparam logic [7:0] KB_EXT     = 8'hE0;
  localparam logic [7:0] KB_BRK     = 8'hF0;
  localparam logic [7:0] KB_BAT_OK  = 8'hAA;
  localparam logic [7:0] KB_ECHO    = 8'hEE;
  localparam logic [7:0] KB_CMD_LED = 8'hED;
  localparam logic [7:0] KB_ERR_LO  = 8'h00;
  localparam logic [7:0] KB_ERR_HI  = 8'hFF;

  localparam int EVT_W = 10;

  // Bit 1 = E0 seen, bit 0 = F0 seen, so the state doubles as the prefix flags.
  typedef enum logic [1:0] {
    D_IDLE    = 2'b00,
    D_BRK     = 2'b01,
    D_EXT     = 2'b10,
    D_EXT_BRK = 2'b11
  } dec_state_e;

  typedef enum logic [1:0] {
    C_IDLE     = 2'b00,
    C_SEND     = 2'b01,
    C_WAIT_TX  = 2'b10,
    C_WAIT_ACK = 2'b11
  } cmd_state_e;

  typedef enum logic [2:0] {
    B_CODE    = 3'd0,
    B_ACK     = 3'd1,
    B_RESEND  = 3'd2,
    B_DISCARD = 3'd3,
    B_EXT     = 3'd4,
    B_BRK     = 3'd5
  } byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    byte_class_e c;
    case (b)
      KB_ACK:                                    c = B_ACK;
      KB_RESEND:                                 c = B_RESEND;
      KB_EXT:                                    c = B_EXT;
      KB_BRK:                                    c = B_BRK;
      KB_BAT_OK, KB_ECHO, KB_ERR_LO, KB_ERR_HI:  c = B_DISCARD;
      default:                                   c = B_CODE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/kb_scan_decoder_fifo.sv
// Synchronous first-word-fall-through FIFO for key events; a push that finds
// the FIFO full with no simultaneous pop is dropped and reported on drop.
module kb_event_fifo #(
  parameter int WIDTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/kb_scan_decoder.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes into buffered key events and
// sequences the ED/led-byte LED command with ACK, resend and timeout handling.
module kb_scan_decoder #(
  parameter int FIFO_AW = 4,
  parameter int ACK_TO  = 2000000,
  parameter int RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_done,
  output logic       we_ps2,
  output logic [7:0] tx_data,
  input  logic       rd,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       overflow,
  input  logic       led_we,
  input  logic [2:0] led_val,
  output logic       cmd_busy,
  output logic       cmd_err
);
  import kb_scan_decoder_pkg::*;

  localparam int TW = $clog2(ACK_TO + 1);
  localparam int RW = $clog2(RETRIES + 2);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TO);

  byte_class_e cls;
  logic        ack_in;
  logic        nak_in;

  assign cls    = classify(rx_data);
  assign ack_in = rx_done & (cls == B_ACK);
  assign nak_in = rx_done & (cls == B_RESEND);

  // ---------------- prefix decode and event FIFO ----------------
  dec_state_e       dec_q, dec_d;
  logic [1:0]       dec_bits;
  logic             push;
  logic [EVT_W-1:0] head;
  logic             fifo_empty;
  logic             drop;
  logic             overflow_q, overflow_d;

  assign dec_bits = dec_q;

  always_comb begin
    dec_d = dec_q;
    push  = 1'b0;
    if (rx_done) begin
      case (cls)
        B_EXT:   dec_d = dec_state_e'({1'b1, dec_bits[0]});
        B_BRK:   dec_d = dec_state_e'({dec_bits[1], 1'b1});
        B_CODE: begin
          push  = 1'b1;
          dec_d = D_IDLE;
        end
        default: dec_d = dec_q;
      endcase
    end
  end

  kb_event_fifo #(
    .WIDTH (EVT_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({dec_bits, rx_data}),
    .pop   (rd),
    .dout  (head),
    .empty (fifo_empty),
    .drop  (drop)
  );

  assign overflow_d = overflow_q | drop;
  assign key_valid  = ~fifo_empty;
  // Memory contents are not reset, so the head is masked while the FIFO is empty.
  assign key_code   = key_valid ? head[7:0] : 8'h00;
  assign key_brk    = key_valid & head[8];
  assign key_ext    = key_valid & head[9];
  assign overflow   = overflow_q;

  // ---------------- LED command sequencer ----------------
  cmd_state_e    cmd_q, cmd_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [2:0]    led_q, led_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  always_comb begin
    cmd_d     = cmd_q;
    tx_data_d = tx_data_q;
    led_d     = led_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    we_d      = 1'b0;
    err_d     = 1'b0;
    case (cmd_q)
      C_IDLE: begin
        if (led_we) begin
          led_d     = led_val;
          tx_data_d = KB_CMD_LED;
          retry_d   = '0;
          we_d      = 1'b1;
          cmd_d     = C_SEND;
        end
      end
      C_SEND: begin
        timer_d = TIMER_LOAD;
        cmd_d   = C_WAIT_TX;
      end
      C_WAIT_TX: begin
        if (tx_done) begin
          timer_d = TIMER_LOAD;
          cmd_d   = C_WAIT_ACK;
        end else if (timer_q <= TW'(1)) begin
          err_d = 1'b1;
          cmd_d = C_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      C_WAIT_ACK: begin
        if (ack_in) begin
          if (tx_data_q == KB_CMD_LED) begin
            tx_data_d = {5'b00000, led_q};
            retry_d   = '0;
            we_d      = 1'b1;
            cmd_d     = C_SEND;
          end else begin
            cmd_d = C_IDLE;
          end
        end else if (nak_in) begin
          if (retry_q >= RW'(RETRIES)) begin
            err_d = 1'b1;
            cmd_d = C_IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
            we_d    = 1'b1;
            cmd_d   = C_SEND;
          end
        end else if (timer_q <= TW'(1)) begin
          err_d = 1'b1;
          cmd_d = C_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: cmd_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q      <= D_IDLE;
      overflow_q <= 1'b0;
      cmd_q      <= C_IDLE;
      tx_data_q  <= 8'h00;
      led_q      <= 3'b000;
      retry_q    <= '0;
      timer_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      overflow_q <= overflow_d;
      cmd_q      <= cmd_d;
      tx_data_q  <= tx_data_d;
      led_q      <= led_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign we_ps2   = we_q;
  assign tx_data  = tx_data_q;
  assign cmd_busy = (cmd_q != C_IDLE);
  assign cmd_err  = err_q;

endmodule
